spi_frame_engine: RTL and testbench



---
 rtl/spi_frame_engine_pkg.sv | 28 ++
 rtl/spi_frame_engine_if.sv | 25 ++
 rtl/spi_frame_engine_sync_edge.sv | 35 +++
 rtl/spi_frame_engine.sv | 147 ++++++++++++++
 tb/tb_spi_frame_engine.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/spi_frame_engine_pkg.sv
// Shared constants, FSM encoding and bridge command-word field positions
// for the SPI frame engine.
package spi_frame_pkg;

  localparam int unsigned SPI_OUT_W = 72;
  localparam int unsigned SPI_IN_W  = 40;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    COMMIT = ST_COMMIT
  } state_t;

  // Field layout of spi_out as decoded by the debug bridge
  localparam int unsigned ADDR_MSB    = 71;
  localparam int unsigned ADDR_LSB    = 40;
  localparam int unsigned DATA_MSB    = 39;
  localparam int unsigned DATA_LSB    = 8;
  localparam int unsigned WE_BIT      = 3;
  localparam int unsigned START_BIT   = 2;
  localparam int unsigned RST_SYS_BIT = 1;
  localparam int unsigned RST_CPU_BIT = 0;

endpackage

// File: rtl/spi_frame_engine_if.sv
// SPI pins plus the parallel command/status words exchanged with the bridge.
interface spi_frame_engine_if #(
  parameter int unsigned OUT_W = 72,
  parameter int unsigned IN_W  = 40
);
  logic             spi_sck;
  logic             spi_cs_n;
  logic             spi_mosi;
  logic             spi_miso;
  logic             spi_miso_oe;
  logic [OUT_W-1:0] spi_out;
  logic [IN_W-1:0]  spi_in;
  logic             frame_valid;
  logic             frame_err;

  modport master (
    output spi_sck, spi_cs_n, spi_mosi, spi_in,
    input  spi_miso, spi_miso_oe, spi_out, frame_valid, frame_err
  );

  modport slave (
    input  spi_sck, spi_cs_n, spi_mosi, spi_in,
    output spi_miso, spi_miso_oe, spi_out, frame_valid, frame_err
  );
endinterface

// File: rtl/spi_frame_engine_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses
// derived from one trailing edge-detect flop.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_sr;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_sr <= {STAGES{RST_VAL}};
      prev    <= RST_VAL;
    end else begin
      sync_sr[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_sr[i] <= sync_sr[i-1];
      end
      prev <= sync_sr[STAGES-1];
    end
  end

  assign q    = sync_sr[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_frame_engine.sv
// Oversampled SPI mode-0 slave: deserialises MOSI into spi_out on complete
// frames and serialises a CS-fall snapshot of spi_in onto MISO.
module spi_frame_engine
  import spi_frame_pkg::*;
#(
  parameter int unsigned OUT_W       = SPI_OUT_W,
  parameter int unsigned IN_W        = SPI_IN_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_frame_engine_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(OUT_W + 2);
  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(OUT_W + 1);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES);

  logic sck_q, sck_rise, sck_fall;
  logic cs_q, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sr;
  logic mosi_q;

  state_t            state;
  logic [CNT_W-1:0]  bitcnt;
  logic              overrun;
  logic [OUT_W-1:0]  rx_sr;
  logic [IN_W-1:0]   tx_sr;
  logic [OUT_W-1:0]  out_q;
  logic              miso_q, miso_oe_q, valid_q, err_q;
  logic [FILL_W-1:0] fill_cnt;
  logic              armed;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.spi_sck),
    .q    (sck_q),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.spi_cs_n),
    .q    (cs_q),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // Same depth as the SCK path so MOSI is sampled at the SCK-rise instant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sr <= '0;
    end else begin
      mosi_sr[0] <= bus.spi_mosi;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        mosi_sr[i] <= mosi_sr[i-1];
      end
    end
  end
  assign mosi_q = mosi_sr[SYNC_STAGES-1];

  // armed: CS must be seen high on the real pin after reset before a fall
  // counts, so a frame straddling reset release is never picked up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bitcnt    <= '0;
      overrun   <= 1'b0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      out_q     <= '0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      fill_cnt  <= '0;
      armed     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;

      if (fill_cnt != FILL_DONE) begin
        fill_cnt <= fill_cnt + 1'b1;
      end else if (cs_q) begin
        armed <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (cs_fall && armed) begin
            tx_sr     <= bus.spi_in;
            miso_q    <= bus.spi_in[IN_W-1];
            miso_oe_q <= 1'b1;
            bitcnt    <= '0;
            overrun   <= 1'b0;
            state     <= SHIFT;
          end
        end

        SHIFT: begin
          if (cs_rise) begin
            miso_oe_q <= 1'b0;
            miso_q    <= 1'b0;
            state     <= COMMIT;
          end else begin
            if (sck_rise) begin
              rx_sr <= {rx_sr[OUT_W-2:0], mosi_q};
              if (bitcnt != CNT_SAT) begin
                bitcnt <= bitcnt + 1'b1;
                if (bitcnt == CNT_FULL) overrun <= 1'b1;
              end
            end
            // Zero fill means MISO naturally reads 0 once IN_W bits are out
            if (sck_fall) begin
              tx_sr  <= {tx_sr[IN_W-2:0], 1'b0};
              miso_q <= tx_sr[IN_W-2];
            end
          end
        end

        COMMIT: begin
          if (bitcnt == CNT_FULL && !overrun) begin
            out_q   <= rx_sr;
            valid_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.spi_out     = out_q;
  assign bus.spi_miso    = miso_q;
  assign bus.spi_miso_oe = miso_oe_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_spi_frame_engine.sv
// Directed bench for spi_frame_engine: vector table of SPI frames plus
// hand-written reset-mid-frame and back-to-back sequences.
module tb_spi_frame_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;

  spi_frame_engine_if #(.OUT_W(72), .IN_W(40)) bus ();

  spi_frame_engine #(.OUT_W(72), .IN_W(40), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;
  logic [71:0] vlog[$];

  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) begin
      n_valid++;
      vlog.push_back(bus.spi_out);
    end
    if (bus.frame_err === 1'b1) n_err++;
  end

  typedef struct {
    logic [127:0] data;
    int           nbits;
    int           half;
    logic [39:0]  din;
    logic [71:0]  exp_out;
    int           exp_v;
    int           exp_e;
    bit           chk_miso;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master: MOSI changes after SCK fall, MISO sampled just before SCK rise
  task automatic send_frame(input logic [127:0] data, input int nbits, input int half,
                            input int gap, input bit mid_change,
                            output logic [127:0] cap, output logic oe_seen);
    cap = '0;
    oe_seen = 1'b0;
    bus.spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = data[nbits-1-i];
      if (mid_change && i == 20) bus.spi_in = 40'h1122334455;
      wait_clks(half);
      cap[nbits-1-i] = bus.spi_miso;
      if (i == 0) oe_seen = bus.spi_miso_oe;
      bus.spi_sck = 1'b1;
      wait_clks(half);
      bus.spi_sck = 1'b0;
    end
    wait_clks(half < 2 ? 2 : half);
    if (nbits == 0) oe_seen = bus.spi_miso_oe;
    bus.spi_cs_n = 1'b1;
    wait_clks(gap);
  endtask

  initial begin
    logic [127:0] cap;
    logic         oe;
    int           v0, e0;

    bus.spi_sck  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    bus.spi_in   = '0;

    vecs[0] = '{128'h12345678DEADBEEF0C, 72, 4, 40'h0, 72'h12345678DEADBEEF0C, 1, 0, 1'b0};
    vecs[1] = '{128'hA5A500001111222233, 72, 8, 40'hCAFEBABE07, 72'hA5A500001111222233, 1, 0, 1'b1};
    vecs[2] = '{128'hFFFFFFFFFFFFFFFFFF, 72, 4, 40'h0, 72'hFFFFFFFFFFFFFFFFFF, 1, 0, 1'b0};
    vecs[3] = '{128'h0123456789, 40, 4, 40'h0, 72'hFFFFFFFFFFFFFFFFFF, 0, 1, 1'b0};
    vecs[4] = '{128'h1_23456789ABCDEF0123, 73, 4, 40'h0, 72'hFFFFFFFFFFFFFFFFFF, 0, 1, 1'b0};
    vecs[5] = '{128'h000000010000000008, 72, 4, 40'h0, 72'h000000010000000008, 1, 0, 1'b0};
    vecs[6] = '{128'h0, 0, 4, 40'h0, 72'h000000010000000008, 0, 1, 1'b0};

    wait_clks(3);
    chk("reset_spi_out", bus.spi_out, 72'h0);
    chk("reset_miso", bus.spi_miso, 1'b0);
    chk("reset_miso_oe", bus.spi_miso_oe, 1'b0);
    chk("reset_valid", bus.frame_valid, 1'b0);
    chk("reset_err", bus.frame_err, 1'b0);
    rst = 1'b0;
    wait_clks(10);

    for (int k = 0; k < 7; k++) begin
      bus.spi_in = vecs[k].din;
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[k].data, vecs[k].nbits, vecs[k].half, 10, vecs[k].chk_miso, cap, oe);
      chk($sformatf("v%0d_spi_out", k), bus.spi_out, vecs[k].exp_out);
      chk($sformatf("v%0d_valid_pulses", k), n_valid - v0, vecs[k].exp_v);
      chk($sformatf("v%0d_err_pulses", k), n_err - e0, vecs[k].exp_e);
      chk($sformatf("v%0d_oe_during", k), oe, 1'b1);
      chk($sformatf("v%0d_oe_after", k), bus.spi_miso_oe, 1'b0);
      if (vecs[k].chk_miso)
        chk($sformatf("v%0d_miso_bits", k), cap[71:0], {40'hCAFEBABE07, 32'h0});
    end

    // Reset after 30 bits, released with CS still low
    v0 = n_valid;
    e0 = n_err;
    bus.spi_cs_n = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.spi_mosi = i[0];
      wait_clks(4);
      bus.spi_sck = 1'b1;
      wait_clks(4);
      bus.spi_sck = 1'b0;
    end
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(6);
    bus.spi_cs_n = 1'b1;
    wait_clks(12);
    chk("rstmid_spi_out", bus.spi_out, 72'h0);
    chk("rstmid_valid_pulses", n_valid - v0, 0);
    chk("rstmid_err_pulses", n_err - e0, 0);
    send_frame(128'h0F0E0D0C0B0A090807, 72, 4, 10, 1'b0, cap, oe);
    chk("rstmid_next_spi_out", bus.spi_out, 72'h0F0E0D0C0B0A090807);
    chk("rstmid_next_valid", n_valid - v0, 1);

    // Back-to-back frames at clk/4, CS high for 2 clk cycles between them
    v0 = n_valid;
    e0 = n_err;
    send_frame(128'h5A5A5A5A3C3C3C3C81, 72, 2, 2, 1'b0, cap, oe);
    send_frame(128'h0123456789ABCDEF42, 72, 2, 10, 1'b0, cap, oe);
    chk("b2b_valid_pulses", n_valid - v0, 2);
    chk("b2b_err_pulses", n_err - e0, 0);
    if (n_valid - v0 >= 2) begin
      chk("b2b_first_word", vlog[vlog.size()-2], 72'h5A5A5A5A3C3C3C3C81);
      chk("b2b_second_word", vlog[vlog.size()-1], 72'h0123456789ABCDEF42);
    end
    chk("b2b_spi_out", bus.spi_out, 72'h0123456789ABCDEF42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
